// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - recovers a duty word from a PWM stream by counting high samples per window
module pwm_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_valid,
  output logic             locked
);

  typedef enum logic {SEEK, MEASURE} state_t;

  localparam logic [WIDTH-1:0] WIN_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TOL      = WIDTH'(LOCK_TOL);
  localparam logic [WIDTH:0]   ONE      = {{WIDTH{1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH-1:0]       win_cnt;
  logic [WIDTH-1:0]       win_cnt_nxt;
  logic [WIDTH:0]         high_cnt;
  logic [WIDTH:0]         high_cnt_nxt;
  logic [WIDTH:0]         total;
  logic                   win_end;

  logic [WIDTH-1:0]       meas;
  logic [WIDTH-1:0]       diff;
  logic [1:0]             done_cnt;
  logic [1:0]             done_nxt;
  logic                   agree;

  // pwm_in is asynchronous: only the last synchronizer stage feeds the logic below
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // State and window counters; the window never realigns once measuring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEEK;
      win_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      state    <= state_nxt;
      win_cnt  <= win_cnt_nxt;
      high_cnt <= high_cnt_nxt;
    end
  end

  // Next-state: SEEK aligns to the first rise (or gives up after one window of constant input)
  always_comb begin
    state_nxt    = state;
    win_cnt_nxt  = win_cnt;
    high_cnt_nxt = high_cnt;
    win_end      = 1'b0;
    total        = high_cnt + {{WIDTH{1'b0}}, s};
    case (state)
      SEEK: begin
        if (rise) begin
          state_nxt    = MEASURE;
          win_cnt_nxt  = {{(WIDTH-1){1'b0}}, 1'b1};
          high_cnt_nxt = ONE;
        end else if (win_cnt == WIN_LAST) begin
          state_nxt    = MEASURE;
          win_cnt_nxt  = '0;
          high_cnt_nxt = '0;
        end else begin
          win_cnt_nxt  = win_cnt + 1'b1;
        end
      end
      MEASURE: begin
        win_cnt_nxt = win_cnt + 1'b1;
        if (win_cnt == WIN_LAST) begin
          win_end      = 1'b1;
          high_cnt_nxt = '0;
        end else begin
          high_cnt_nxt = total;
        end
      end
      default: begin
        state_nxt = SEEK;
      end
    endcase
  end

  // Result and lock evaluation; an all-high window (count 2**WIDTH) saturates
  always_comb begin
    meas     = total[WIDTH] ? WIN_LAST : total[WIDTH-1:0];
    diff     = (meas >= duty_out) ? (meas - duty_out) : (duty_out - meas);
    done_nxt = (done_cnt == 2'd2) ? 2'd2 : (done_cnt + 2'd1);
    agree    = (done_nxt == 2'd2) && (diff <= TOL);
  end

  // Publish a result one clock after the window's last sample; locked holds between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_out   <= '0;
      duty_valid <= 1'b0;
      locked     <= 1'b0;
      done_cnt   <= 2'd0;
    end else begin
      duty_valid <= win_end;
      if (win_end) begin
        duty_out <= meas;
        locked   <= agree;
        done_cnt <= done_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - directed scoreboard bench for pwm_decoder driven by a pwm encoder model
module tb_pwm_decoder;

  typedef struct {
    int   lo;
    int   hi;
    logic lk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] duty_out;
  logic       duty_valid;
  logic       locked;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  logic [7:0] enc_cnt = 8'h80;
  int         enc_duty = 0;
  bit         level_mode = 1'b0;
  bit         level = 1'b0;
  bit         ramp_on = 1'b0;
  int         ramp_val = 0;
  localparam int RAMP_END = 127;
  localparam int FIRST_MAX = 2 * 256 + 2 + 2;

  pwm_decoder #(.WIDTH(8), .SYNC_STAGES(2), .LOCK_TOL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .duty_valid(duty_valid),
    .locked    (locked)
  );

  always #2 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clock: encoder model advances, ramp pushes the expectation for each new period
  task automatic tick();
    @(posedge clk);
    #1;
    enc_cnt = enc_cnt + 8'd1;
    if (ramp_on && enc_cnt == 8'd0) begin
      enc_duty = ramp_val;
      sb.push_back('{(ramp_val == 0) ? 0 : ramp_val - 1, ramp_val + 1, (ramp_val != 0)});
      ramp_val++;
      if (ramp_val > RAMP_END) ramp_on = 1'b0;
    end
    pwm_in = level_mode ? level : (int'(enc_cnt) < enc_duty);
  endtask

  task automatic wait_result(input string tag, input int budget, output int n);
    exp_t e;
    n = 0;
    do begin
      tick();
      n++;
    end while (duty_valid !== 1'b1 && n < budget);
    checks++;
    assert (duty_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d expected=1", tag, duty_valid);
    end
    if (duty_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL %s_unexpected observed=%0d expected=none", tag, duty_out);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_rng({tag, "_duty"}, int'(duty_out), e.lo, e.hi);
        chk({tag, "_lock"}, int'(locked), int'(e.lk));
      end
    end
  endtask

  task automatic do_reset(input bit lm, input bit lv, input int d);
    rst_n = 1'b0;
    level_mode = lm;
    level = lv;
    enc_duty = d;
    enc_cnt = 8'h80;
    ramp_on = 1'b0;
    sb.delete();
    repeat (4) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit seen;

    // reset state
    repeat (3) tick();
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_lock", int'(locked), 0);

    // case 1: steady D=0x40
    do_reset(1'b0, 1'b0, 'h40);
    sb.push_back('{'h40, 'h40, 1'b0});
    wait_result("c1_first", 600, n);
    chk("c1_first_latency_ok", int'(n <= FIRST_MAX), 1);
    sb.push_back('{'h40, 'h40, 1'b1});
    wait_result("c1_second", 600, n);
    chk("c1_period", n, 256);

    // case 2: constant low, SEEK times out
    do_reset(1'b1, 1'b0, 0);
    sb.push_back('{0, 0, 1'b0});
    sb.push_back('{0, 0, 1'b1});
    sb.push_back('{0, 0, 1'b1});
    repeat (3) wait_result("c2_low", 700, n);

    // case 3: constant high saturates
    do_reset(1'b1, 1'b1, 0);
    sb.push_back('{255, 255, 1'b0});
    sb.push_back('{255, 255, 1'b1});
    sb.push_back('{255, 255, 1'b1});
    repeat (3) wait_result("c3_high", 700, n);

    // case 4: duty step mid-window
    do_reset(1'b0, 1'b0, 'h10);
    sb.push_back('{'h10, 'h10, 1'b0});
    sb.push_back('{'h10, 'h10, 1'b1});
    repeat (2) wait_result("c4_pre", 600, n);
    n = 0;
    while (enc_cnt != 8'h80 && n < 300) begin
      tick();
      n++;
    end
    enc_duty = 'hF0;
    sb.push_back('{'h11, 'hEF, 1'b0});
    wait_result("c4_transient", 600, n);
    sb.push_back('{'hF0, 'hF0, 1'b0});
    wait_result("c4_new", 600, n);

    // case 5: slow ramp, one step per encoder period
    sb.push_back('{'hF0, 'hF0, 1'b1});
    ramp_val = 0;
    ramp_on = 1'b1;
    n = 0;
    while ((sb.size() > 0 || ramp_on) && n < 400) begin
      wait_result("c5_ramp", 600, n);
    end

    // case 6: reset pulsed mid-window
    do_reset(1'b0, 1'b0, 'h40);
    sb.push_back('{'h40, 'h40, 1'b0});
    wait_result("c6_pre", 600, n);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("c6_async_duty", int'(duty_out), 0);
    chk("c6_async_valid", int'(duty_valid), 0);
    chk("c6_async_lock", int'(locked), 0);
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (duty_valid === 1'b1) seen = 1'b1;
    end
    chk("c6_no_partial_valid", int'(seen), 0);
    rst_n = 1'b1;
    sb.push_back('{'h40, 'h40, 1'b0});
    wait_result("c6_first", 600, n);
    chk("c6_first_latency_ok", int'(n <= FIRST_MAX), 1);
    sb.push_back('{'h40, 'h40, 1'b1});
    wait_result("c6_second", 600, n);
    chk("c6_period", n, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
